pc_fetch_unit: RTL
==================

// Module: pc_fetch_unit
// PURPOSE
//  Program counter and fetch sequencer. Drives InstAddress into the instruction ROM, takes the
//  returned 9-bit word back, and picks the next PC: sequential, JUMP or conditional branch via a
//  16-entry target LUT. Also runs the start/halt handshake with the testbench or top level.
//  Sits directly upstream of the ROM. Its instruction output feeds the decoder/register file.
// PARAMETERS
//  ROM_DEPTH    512  valid ROM words; a PC reaching ROM_DEPTH-1 without HALT is a fault
//  NUM_PROGS    3    selectable program entry points
//  CNT_W        16   width of the retired-instruction counter
// PORTS
//  Clk          in   1        clock; all state updates on rising edge
//  Reset_n      in   1        synchronous reset, active low
//  Start        in   1        one-cycle pulse; accepted in IDLE or HALTED only
//  ProgSel      in   2        program to launch; sampled with Start (0..NUM_PROGS-1)
//  Stall        in   1        hold PC and state this cycle (multi-cycle data memory op)
//  CondFlag     in   1        registered compare result from SEQ/SLT (ALU flag register)
//  InstIn       in   9        instruction word returned by ROM for current InstAddress
//  InstAddress  out  10       registered PC
//  InstValid    out  1        1 while in RUN; decoder ignores InstIn when 0
//  Done         out  1        1 in HALTED after a clean HALT
//  Fault        out  1        1 in HALTED after a PC-overrun or bad ProgSel
//  RetiredCnt   out  CNT_W    instructions retired since the last accepted Start; saturates
// BEHAVIOUR
//  - Reset (Reset_n=0 at edge, overrides everything including mid-RUN):
//    state=IDLE, InstAddress=0, InstValid=0, Done=0, Fault=0, RetiredCnt=0.
//  - FSM states: IDLE, RUN, HALTED.
//    - IDLE/HALTED with Start=1 and ProgSel<NUM_PROGS: next state RUN.
//      InstAddress=ENTRY[ProgSel]; Done, Fault and RetiredCnt clear.
//    - Start with ProgSel>=NUM_PROGS: next state HALTED, Fault=1, InstAddress unchanged.
//    - Start while in RUN: ignored.
//  - ROM is combinational, so InstIn is valid in the same cycle as InstAddress.
//  - Each RUN cycle with Stall=0 retires InstIn. Decode priority (first match wins):
//    1. InstIn==9'h1FF (HALT): state HALTED, Done=1, PC holds, retired counted.
//    2. InstIn[8:4]==5'b01101 (JUMP): PC=LUT[InstIn[3:0]].
//    3. InstIn[8:4]==5'b10001 (BONE): PC = CondFlag ? LUT[idx] : PC+1.
//    4. InstIn[8:4]==5'b10011 (BZERO): PC = !CondFlag ? LUT[idx] : PC+1.
//    5. Any other word: PC=PC+1.
//  - Overrun: a sequential step with PC==ROM_DEPTH-1 goes to HALTED with Fault=1, Done=0,
//    PC holds. Taken branches to any LUT value are legal.
//  - Stall=1 in RUN: PC, state and RetiredCnt hold. CondFlag is not sampled. Stall is ignored
//    outside RUN.
//  - Latency: one cycle from Start to the first InstValid. A branch is taken on the edge
//    following its fetch, so there are zero bubbles.
//  - RetiredCnt increments once per retired instruction and sticks at 2^CNT_W-1.
//  - Done and Fault are mutually exclusive and hold until the next accepted Start or reset.
// STRUCTURE
//  - Shared package isa_pkg:
//    - opcode field constants OP_JUMP=5'b01101, OP_BONE=5'b10001, OP_BZERO=5'b10011,
//      INST_HALT=9'h1FF
//    - typedef fetch_state_t {IDLE,RUN,HALTED}
//    - ENTRY[NUM_PROGS] = '{10'd0, 10'd65, 10'd166}
//    - BR_LUT[16] target table, owned by the program author
//  - Sub-module branch_lut: combinational 4-bit index -> 10-bit target, reading BR_LUT.
//  - Top level holds the FSM, PC register, next-PC mux and counter.
// TESTING
//  1. Reset_n=0 for 2 cycles during RUN at PC=37 -> next cycle InstAddress=0, InstValid=0,
//     Done=0, RetiredCnt=0, state IDLE.
//  2. Start, ProgSel=1 -> next cycle InstAddress=65, InstValid=1. Feed 3 non-branch words ->
//     PC 66, 67, 68, RetiredCnt=3.
//  3. BR_LUT[1]=64. At PC=6 feed 9'b100010001 with CondFlag=1 -> PC=64. Repeat with CondFlag=0
//     -> PC=7. BZERO 9'b100111101 (idx 13) with CondFlag=0 -> PC=BR_LUT[13].
//  4. Feed JUMP 9'b011010000 with BR_LUT[0]=4 and Stall=1 for 2 cycles -> PC holds at the same
//     address both cycles. Stall drops -> PC=4 next edge; RetiredCnt +1 only.
//  5. HALT 9'h1FF at PC=64 -> Done=1, InstValid=0, PC stays 64. Start in RUN beforehand is
//     ignored; Start ProgSel=2 after HALT -> PC=166, Done=0.
//  6. Run sequential words from PC=509 -> PC 510, 511, then HALTED with Fault=1, Done=0.
//     Start with ProgSel=3 -> Fault=1.
//  Bench also checks: Done&&Fault never both 1; RetiredCnt saturates with CNT_W=4 after 15.

Source files
------------

// File: rtl/isa_pkg.sv
// Shared ISA constants for the fetch path: opcode fields, fetch FSM encoding,
// program entry points and the program author's branch target table.
package isa_pkg;

  localparam logic [4:0] OP_JUMP   = 5'b01101;
  localparam logic [4:0] OP_BONE   = 5'b10001;
  localparam logic [4:0] OP_BZERO  = 5'b10011;
  localparam logic [8:0] INST_HALT = 9'h1FF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  localparam int NUM_ENTRY = 3;
  localparam logic [9:0] ENTRY [NUM_ENTRY] = '{10'd0, 10'd65, 10'd166};

  localparam logic [9:0] BR_LUT [16] = '{
    10'd4,   10'd64,  10'd37,  10'd6,
    10'd30,  10'd40,  10'd50,  10'd60,
    10'd70,  10'd80,  10'd90,  10'd100,
    10'd110, 10'd300, 10'd400, 10'd509
  };

  // Out-of-range selectors never reach here; the caller rejects them first.
  function automatic logic [9:0] entry_pc(input logic [1:0] sel);
    case (sel)
      2'd1:    return ENTRY[1];
      2'd2:    return ENTRY[2];
      default: return ENTRY[0];
    endcase
  endfunction

endpackage

// File: rtl/pc_fetch_unit_branch_lut.sv
// Branch target lookup: 4-bit index from the instruction word to a 10-bit PC.
module branch_lut
  import isa_pkg::*;
(
  input  logic [3:0] idx,
  output logic [9:0] target
);

  assign target = BR_LUT[idx];

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and fetch sequencer: start/halt handshake, next-PC selection
// (sequential, jump, conditional branch) and a saturating retired-instruction counter.
module pc_fetch_unit
  import isa_pkg::*;
#(
  parameter int ROM_DEPTH = 512,
  parameter int NUM_PROGS = 3,
  parameter int CNT_W     = 16
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [1:0]       ProgSel,
  input  logic             Stall,
  input  logic             CondFlag,
  input  logic [8:0]       InstIn,
  output logic [9:0]       InstAddress,
  output logic             InstValid,
  output logic             Done,
  output logic             Fault,
  output logic [CNT_W-1:0] RetiredCnt
);

  fetch_state_t     state, state_nx;
  logic [9:0]       pc_nx;
  logic             done_nx, fault_nx;
  logic [CNT_W-1:0] cnt_nx;
  logic [9:0]       lut_tgt;
  logic [4:0]       opcode;
  logic             is_halt, take_lut;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  branch_lut u_lut (
    .idx    (InstIn[3:0]),
    .target (lut_tgt)
  );

  assign opcode   = InstIn[8:4];
  assign is_halt  = (InstIn == INST_HALT);
  assign take_lut = (opcode == OP_JUMP) ||
                    ((opcode == OP_BONE)  &&  CondFlag) ||
                    ((opcode == OP_BZERO) && !CondFlag);

  always_comb begin
    state_nx = state;
    pc_nx    = InstAddress;
    done_nx  = Done;
    fault_nx = Fault;
    cnt_nx   = RetiredCnt;
    case (state)
      RUN: begin
        if (!Stall) begin
          cnt_nx = sat_inc(RetiredCnt);
          if (is_halt) begin
            state_nx = HALTED;
            done_nx  = 1'b1;
          end else if (take_lut) begin
            pc_nx = lut_tgt;
          end else if (InstAddress == 10'(ROM_DEPTH - 1)) begin
            // Falling off the end of the ROM without a HALT.
            state_nx = HALTED;
            fault_nx = 1'b1;
          end else begin
            pc_nx = InstAddress + 10'd1;
          end
        end
      end
      default: begin
        if (Start) begin
          if (int'(ProgSel) < NUM_PROGS) begin
            state_nx = RUN;
            pc_nx    = entry_pc(ProgSel);
            done_nx  = 1'b0;
            fault_nx = 1'b0;
            cnt_nx   = '0;
          end else begin
            state_nx = HALTED;
            done_nx  = 1'b0;
            fault_nx = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state       <= IDLE;
      InstAddress <= '0;
      Done        <= 1'b0;
      Fault       <= 1'b0;
      RetiredCnt  <= '0;
    end else begin
      state       <= state_nx;
      InstAddress <= pc_nx;
      Done        <= done_nx;
      Fault       <= fault_nx;
      RetiredCnt  <= cnt_nx;
    end
  end

  assign InstValid = (state == RUN);

endmodule
